bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data width of every channel.
REQ-002 Parameter N_CH, default 4, range 2..16, SHALL set the number of master channels.
REQ-003 Parameter DEPTH, default 4, power of two >= 2, SHALL set the output FIFO entry count.
REQ-004 Derived CH_W = max(1, clog2(N_CH)); CNT_W = clog2(DEPTH+1).
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 in_valid  input  N_CH  per-channel request; bit i belongs to channel i.
REQ-009 in_data  input  N_CH*DATA_W  channel i data in bits [i*DATA_W +: DATA_W].
REQ-010 in_ready  output  N_CH  per-channel accept.
REQ-011 out_valid  output  1  FIFO head valid.
REQ-012 out_data  output  DATA_W  FIFO head data.
REQ-013 out_ch  output  CH_W  source channel of the FIFO head.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 count  output  CNT_W  current FIFO occupancy.

Function
REQ-016 Input transfer on channel i SHALL occur on a rising edge where in_valid[i] and in_ready[i] are both 1.
REQ-017 Output transfer SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-018 in_ready SHALL be one-hot or zero. It SHALL be zero whenever the FIFO is full; a pop in the same cycle does not lift that condition (no full-bypass).
REQ-019 in_ready SHALL be combinational from in_valid and state. in_ready[i] may rise only when in_valid[i] is 1.
REQ-020 Grant SHALL be round-robin. Search starts at channel (last+1) mod N_CH and selects the first channel with in_valid set.
REQ-021 last SHALL update to the granted channel only on an accepted input transfer. Without a transfer, last holds.
REQ-022 Each accepted transfer SHALL write {channel id, data} into the FIFO tail.
REQ-023 An accepted word SHALL be visible on out_valid/out_data/out_ch on the next cycle, giving 1-cycle latency.
REQ-024 The FIFO SHALL be show-ahead: out_valid = (count != 0), and head fields are stable while out_valid=1 and out_ready=0.
REQ-025 Simultaneous push and pop when not full and not empty SHALL leave count unchanged and preserve order.
REQ-026 out_ready with an empty FIFO SHALL be ignored, with no pointer movement.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH. count SHALL never exceed DEPTH and SHALL never underflow.
REQ-028 Fairness: a channel holding in_valid=1 SHALL be accepted within N_CH consecutive accepted transfers.
REQ-029 Channel data SHALL never be reordered; per-channel order SHALL equal acceptance order.

Reset
REQ-030 Asserting rst SHALL immediately set count=0, out_valid=0, in_ready=0, FIFO pointers=0, last=N_CH-1.
REQ-031 After rst deasserts, channel 0 SHALL have first priority.
REQ-032 FIFO contents SHALL be discarded by reset mid-operation. Storage RAM need not be cleared; out_data/out_ch are don't-care while out_valid=0.

Structure
REQ-033 Shared package bus_pkg SHALL hold the default DATA_W/N_CH/DEPTH constants and a clog2-based width helper.
REQ-034 The FIFO SHALL be a separate sub-module bus_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).
REQ-035 bus_rr_arbiter SHALL contain only the grant logic, the last register, and a bus_fifo instance of WIDTH = CH_W+DATA_W.

Verification
REQ-036 Single channel: ch2 sends 8'hAB with out_ready=1 -> in_ready[2]=1 same cycle; next cycle out_valid=1, out_data=AB, out_ch=2.
REQ-037 All four channels valid continuously, out_ready=1 -> accepted order ch0,1,2,3,0,1…; no channel is starved.
REQ-038 out_ready=0 with 5 pushes offered (DEPTH=4) -> count reaches 4 and all in_ready=0. Head holds the first word. Raising out_ready drains in order.
REQ-039 Full FIFO with out_ready=1 and ch1 valid -> pop occurs and no push that cycle; push accepted the following cycle; count goes 4->3->4.
REQ-040 rst asserted with count=3 mid-stream -> out_valid=0 and count=0 immediately. Next grant after release goes to ch0.
REQ-041 Random valid/ready stress with N_CH=3, DATA_W=16 -> scoreboard shows per-channel order preserved, no loss or duplication, and the REQ-028 bound holds.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared defaults and width helpers for the round-robin bus arbiter slice.
package bus_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_CH   = 4;
  localparam int DEF_DEPTH  = 4;

  // Channel-index width; a 2-channel bus still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// Show-ahead FIFO with occupancy count; storage is not reset, only control.
module bus_fifo
  import bus_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin N-channel arbiter feeding a show-ahead FIFO tagged with channel id.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int CH_W  = idx_w(N_CH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]        out_ch,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       count
);

  localparam logic [CH_W:0]   NCH_L   = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_RST = CH_W'(N_CH - 1);

  logic [CH_W-1:0]        last;
  logic [N_CH-1:0]        gnt_oh;
  logic [CH_W-1:0]        gnt_ch;
  logic                   gnt_any;
  logic [DATA_W-1:0]      sel_data;
  logic [CH_W:0]          sum;
  logic [CH_W-1:0]        cidx;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic [CH_W+DATA_W-1:0] rdata;

  // Search from last+1 around the ring; first requester wins.
  always_comb begin
    gnt_oh   = '0;
    gnt_ch   = '0;
    gnt_any  = 1'b0;
    sel_data = '0;
    sum      = '0;
    cidx     = '0;
    for (int k = 1; k <= N_CH; k++) begin
      sum = {1'b0, last} + (CH_W+1)'(k);
      if (sum >= NCH_L) sum = sum - NCH_L;
      cidx = sum[CH_W-1:0];
      if (!gnt_any && in_valid[cidx]) begin
        gnt_any      = 1'b1;
        gnt_ch       = cidx;
        gnt_oh[cidx] = 1'b1;
      end
    end
    for (int j = 0; j < N_CH; j++) begin
      if (gnt_oh[j]) sel_data = in_data[j*DATA_W +: DATA_W];
    end
  end

  // No full-bypass: a same-cycle pop does not open a slot for a push.
  assign in_ready = (gnt_any && !fifo_full && !rst) ? gnt_oh : '0;
  assign push     = |in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last <= LAST_RST;
    else if (push) last <= gnt_ch;
  end

  bus_fifo #(
    .WIDTH (CH_W + DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({gnt_ch, sel_data}),
    .pop   (out_ready),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign out_valid = !fifo_empty;
  assign out_ch    = rdata[DATA_W +: CH_W];
  assign out_data  = rdata[DATA_W-1:0];

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench: directed vectors on a 4-channel instance, random stress on a 3-channel one.
module tb_bus_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
  logic [2:0]  count;

  logic        rst3;
  logic [2:0]  in_valid3;
  logic [47:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [15:0] out_data3;
  logic [1:0]  out_ch3;
  logic        out_ready3;
  logic [2:0]  count3;

  bus_rr_arbiter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
    .count(count)
  );

  bus_rr_arbiter #(.DATA_W(16), .N_CH(3), .DEPTH(4)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3), .out_ready(out_ready3),
    .count(count3)
  );

  int checks = 0;
  int failures = 0;
  logic [9:0]  exp_q[$];
  logic [15:0] sq[3][$];
  int wait_cnt[3];
  int seq[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] d0, input logic [7:0] d1,
                                     input logic [7:0] d2, input logic [7:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // Output monitor, main instance
  always @(negedge clk) begin : mon
    logic [9:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%0h/%0h required=none", out_ch, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_ch", {30'b0, out_ch}, {22'b0, e[9:8]});
        chk("out_data", {24'b0, out_data}, {24'b0, e[7:0]});
      end
    end
  end

  // Output monitor, stress instance
  always @(negedge clk) begin : mon3
    logic [15:0] e;
    if (!rst3 && out_valid3 && out_ready3) begin
      if (out_ch3 > 2'd2 || sq[out_ch3].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL s_unexpected_out actual=%0h/%0h required=none", out_ch3, out_data3);
      end else begin
        e = sq[out_ch3].pop_front();
        chk("s_out_data", {16'b0, out_data3}, {16'b0, e});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b1;
    #2;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {28'b0, in_ready}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
  endtask

  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic ordy,
                      input logic [3:0] exp_rdy, input int exp_cnt, input string name);
    int ch;
    in_valid = v;
    in_data = d;
    out_ready = ordy;
    @(negedge clk);
    chk({name, "_in_ready"}, {28'b0, in_ready}, {28'b0, exp_rdy});
    chk({name, "_count"}, {29'b0, count}, exp_cnt);
    chk({name, "_out_valid"}, {31'b0, out_valid}, {31'b0, exp_cnt != 0});
    if (exp_rdy != 4'b0) begin
      ch = 0;
      for (int c = 0; c < 4; c++) if (exp_rdy[c]) ch = c;
      exp_q.push_back({2'(ch), d[ch*8 +: 8]});
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rowdata(input int i);
    logic [7:0] b;
    b = 8'(16 * i);
    return pk(b, b + 8'd1, b + 8'd2, b + 8'd3);
  endfunction

  task automatic stress();
    logic [2:0] acc;
    in_valid3 = '0;
    out_ready3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      seq[c] = 0;
      wait_cnt[c] = 0;
      in_data3[c*16 +: 16] = {4'(c), 12'd0};
    end
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < 3; c++)
        if (!in_valid3[c] && $urandom_range(0, 2) != 0) in_valid3[c] = 1'b1;
      out_ready3 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("s_onehot", {31'b0, $onehot0(in_ready3)}, 32'd1);
      chk("s_ready_needs_valid", {29'b0, in_ready3 & ~in_valid3}, 32'd0);
      acc = in_ready3 & in_valid3;
      if (acc != 3'b0) begin
        for (int c = 0; c < 3; c++) begin
          if (acc[c]) begin
            sq[c].push_back(in_data3[c*16 +: 16]);
            chk("s_fair", {31'b0, wait_cnt[c] <= 2}, 32'd1);
            wait_cnt[c] = 0;
          end else if (in_valid3[c]) begin
            wait_cnt[c]++;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
        if (acc[c]) begin
          seq[c]++;
          in_data3[c*16 +: 16] = {4'(c), 12'(seq[c])};
          in_valid3[c] = ($urandom_range(0, 1) == 1);
        end
      end
    end
    in_valid3 = '0;
    out_ready3 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("s_drain_count", {29'b0, count3}, 32'd0);
    for (int c = 0; c < 3; c++) chk("s_drain_left", sq[c].size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rst3 = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    in_valid3 = '0;
    in_data3 = '0;
    out_ready3 = 1'b0;

    // Single channel: ch2 sends AB
    do_reset();
    step(4'b0100, pk(8'h00, 8'h00, 8'hAB, 8'h00), 1'b1, 4'b0100, 0, "t1_push");
    step(4'b0000, 32'h0, 1'b1, 4'b0000, 1, "t1_out");
    step(4'b0000, 32'h0, 1'b1, 4'b0000, 0, "t1_idle");

    // All channels requesting, steady drain
    do_reset();
    for (int i = 0; i < 8; i++)
      step(4'hF, rowdata(i), 1'b1, 4'(1 << (i % 4)), (i == 0) ? 0 : 1, "t2_rr");
    step(4'h0, 32'h0, 1'b1, 4'b0000, 1, "t2_tail");
    step(4'h0, 32'h0, 1'b1, 4'b0000, 0, "t2_empty");

    // Fill to full with out_ready low, head holds, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++)
      step(4'hF, rowdata(i + 4), 1'b0, 4'(1 << i), i, "t3_fill");
    step(4'hF, rowdata(9), 1'b0, 4'b0000, 4, "t3_full");
    chk("t3_head_data", {24'b0, out_data}, 32'h40);
    chk("t3_head_ch", {30'b0, out_ch}, 32'd0);
    for (int j = 0; j < 4; j++)
      step(4'h0, 32'h0, 1'b1, 4'b0000, 4 - j, "t3_drain");
    step(4'h0, 32'h0, 1'b0, 4'b0000, 0, "t3_empty");

    // Full with pop: no push that cycle, push next cycle
    do_reset();
    for (int i = 0; i < 4; i++)
      step(4'hF, rowdata(i + 10), 1'b0, 4'(1 << i), i, "t4_fill");
    step(4'b0010, pk(8'h00, 8'h77, 8'h00, 8'h00), 1'b1, 4'b0000, 4, "t4_popfull");
    step(4'b0010, pk(8'h00, 8'h77, 8'h00, 8'h00), 1'b0, 4'b0010, 3, "t4_push");
    step(4'b0000, 32'h0, 1'b0, 4'b0000, 4, "t4_refull");
    for (int j = 0; j < 4; j++)
      step(4'h0, 32'h0, 1'b1, 4'b0000, 4 - j, "t4_drain");
    step(4'h0, 32'h0, 1'b0, 4'b0000, 0, "t4_empty");

    // Reset mid-stream with three words held
    do_reset();
    for (int i = 0; i < 3; i++)
      step(4'hF, rowdata(i + 5), 1'b0, 4'(1 << i), i, "t5_fill");
    step(4'h0, 32'h0, 1'b0, 4'b0000, 3, "t5_hold");
    do_reset();
    step(4'hF, pk(8'h11, 8'h22, 8'h33, 8'h44), 1'b1, 4'b0001, 0, "t5_after");
    step(4'h0, 32'h0, 1'b1, 4'b0000, 1, "t5_out");
    step(4'h0, 32'h0, 1'b0, 4'b0000, 0, "t5_empty");
    chk("exp_q_left", exp_q.size(), 32'd0);

    stress();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
